// File: rtl/uart_tx_fifo_ctrl.sv
// Byte FIFO feeding a UART transmitter through a start/busy handshake.
// Pops one byte per frame, waits for busy rise (with timeout) and fall, then idles 2 cycles.
module uart_tx_fifo_ctrl #(
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = 4,
  parameter int BUSY_TMO   = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   fifo_cnt,
  output logic              overflow,
  output logic              tx_en,
  output logic [7:0]        uart_din,
  input  logic              uart_tx_busy,
  output logic              tx_done,
  output logic              tx_err
);

  // state     | meaning
  // IDLE      | wait for a queued byte, pop it into uart_din
  // START     | tx_en high for one cycle, timeout counter cleared
  // WAIT_BUSY | wait for transmitter busy rise, give up after BUSY_TMO cycles
  // WAIT_DONE | wait for busy fall, then pulse tx_done
  // GAP       | two cycles of tx_en low before the next start
  typedef enum logic [2:0] {IDLE, START, WAIT_BUSY, WAIT_DONE, GAP} state_t;

  localparam int TMO_W = $clog2(BUSY_TMO + 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(BUSY_TMO - 1);
  localparam logic [ADDR_W:0]  DEPTH_CNT = (ADDR_W + 1)'(FIFO_DEPTH);

  state_t            state, state_nxt;
  logic [7:0]        mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   cnt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              gap_cnt;
  logic              push, pop, tmo_clr, tmo_inc, tx_done_nxt, tx_err_nxt;

  assign full     = (cnt == DEPTH_CNT);
  assign empty    = (cnt == '0);
  assign fifo_cnt = cnt;
  // full is the pre-pop value, so a push at full is dropped even if a pop happens
  assign push     = wr_en && !full;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    pop         = 1'b0;
    tmo_clr     = 1'b0;
    tmo_inc     = 1'b0;
    tx_done_nxt = 1'b0;
    tx_err_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        tmo_clr   = 1'b1;
        state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (uart_tx_busy) begin
          state_nxt = WAIT_DONE;
        end else if (tmo_cnt == TMO_LAST) begin
          tx_err_nxt = 1'b1;
          state_nxt  = GAP;
        end else begin
          tmo_inc = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!uart_tx_busy) begin
          tx_done_nxt = 1'b1;
          state_nxt   = GAP;
        end
      end
      GAP: begin
        if (gap_cnt) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // storage is not reset; only pointers and count define validity
  always_ff @(posedge sys_clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
      tx_en    <= 1'b0;
      uart_din <= 8'h00;
      tx_done  <= 1'b0;
      tx_err   <= 1'b0;
      tmo_cnt  <= '0;
      gap_cnt  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop) begin
        rd_ptr   <= rd_ptr + ADDR_W'(1);
        uart_din <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + (ADDR_W + 1)'(1);
        2'b01:   cnt <= cnt - (ADDR_W + 1)'(1);
        default: cnt <= cnt;
      endcase
      overflow <= wr_en && full;
      tx_en    <= (state_nxt == START);
      tx_done  <= tx_done_nxt;
      tx_err   <= tx_err_nxt;
      if (tmo_clr)      tmo_cnt <= '0;
      else if (tmo_inc) tmo_cnt <= tmo_cnt + TMO_W'(1);
      gap_cnt  <= (state == GAP) && !gap_cnt;
    end
  end

endmodule
